// File: rtl/bist_misr_analyzer_pkg.sv
// Shared definitions for the BIST response analyzer: FSM state encoding,
// MISR feedback taps for x^9+x^5+1, and the default response width.
// Latency: n/a (declarations only). Backpressure: n/a.
package bist_pkg;

  // Response width {ALU_Out, CarryOut}
  localparam int DEF_WIDTH = 9;

  // Feedback taps of x^9+x^5+1: the MSB feeds back into bits 0 and 5
  localparam logic [8:0] MISR_TAP = 9'h021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bist_misr_analyzer_misr.sv
// misr_core: combinational next-state of a multiple-input signature register.
// Latency: zero (pure combinational); the caller owns the state register.
// Backpressure: none; en=0 simply returns the current signature.
module misr_core
  import bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] next_sig
);

  // Taps sized to the response width; the MSB is the feedback bit
  localparam logic [WIDTH-1:0] TAP = WIDTH'(MISR_TAP);

  logic fb;
  assign fb = sig[WIDTH-1];

  // Shift left, fold the feedback bit into the tap positions, absorb the sample
  always_comb begin
    next_sig = sig;
    if (en) begin
      next_sig = {sig[WIDTH-2:0], 1'b0} ^ (fb ? TAP : '0) ^ d;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// bist_misr_analyzer: compacts TEST_LEN response samples into a MISR and compares with golden_sig.
// Latency: done/pass one edge after the final valid sample; signature updates on each accepted sample.
// Backpressure: none; resp_valid=0 holds state, samples outside RUN are dropped. Optional abort via BIST_MISR_ABORT_EN.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               TEST_LEN = 256,
  parameter logic [WIDTH-1:0] SEED     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef BIST_MISR_ABORT_EN
  input  logic             abort,
`endif
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  input  logic [WIDTH-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      sample_cnt
);

  // Count value at which the incoming sample is the final one of the run
  localparam logic [15:0] LAST_CNT = 16'(TEST_LEN - 1);

  state_t           state;
  logic             accept;
  logic             last_sample;
  logic             run_abort;
  logic [WIDTH-1:0] next_sig;

  // A sample counts only while running; anything else leaves the MISR untouched
  assign accept      = (state == RUN) && resp_valid;
  assign last_sample = (sample_cnt == LAST_CNT);

`ifdef BIST_MISR_ABORT_EN
  assign run_abort = abort;
`else
  assign run_abort = 1'b0;
`endif

  misr_core #(
    .WIDTH (WIDTH)
  ) u_misr (
    .sig      (signature),
    .d        (resp_data),
    .en       (accept),
    .next_sig (next_sig)
  );

  // Status flags decode directly from the state register
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Run control FSM with signature, sample counter and compare result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      signature  <= SEED;
      sample_cnt <= 16'd0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            signature  <= SEED;
            sample_cnt <= 16'd0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          // Abort wins over a coincident final sample; that sample is dropped
          if (run_abort) begin
            state <= IDLE;
            pass  <= 1'b0;
          end else if (accept) begin
            signature  <= next_sig;
            sample_cnt <= sample_cnt + 16'd1;
            if (last_sample) begin
              state <= DONE;
              pass  <= (next_sig == golden_sig);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench: two analyzer instances (TEST_LEN=4 and TEST_LEN=2, SEED=0).
// A bit-level MISR model predicts signatures; final results go through a scoreboard queue.
// Define BIST_MISR_ABORT_EN to also exercise the abort path.
module tb_bist_misr_analyzer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       resp_valid;
  logic [8:0] resp_data;
  logic [8:0] golden_sig;
  logic       sel;  // 0: drive/observe the TEST_LEN=4 instance, 1: the TEST_LEN=2 instance

  logic        busy4, done4, pass4, busy2, done2, pass2;
  logic [8:0]  sig4, sig2;
  logic [15:0] cnt4, cnt2;

  logic        obs_busy, obs_done, obs_pass;
  logic [8:0]  obs_sig;
  logic [15:0] obs_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [8:0] stim[$];
  logic [9:0] exp_q[$];  // {signature, pass}

  always #5 clk = ~clk;

  bist_misr_analyzer #(.WIDTH(9), .TEST_LEN(4), .SEED(9'h000)) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start & ~sel),
`ifdef BIST_MISR_ABORT_EN
    .abort      (abort & ~sel),
`endif
    .resp_valid (resp_valid & ~sel),
    .resp_data  (resp_data),
    .golden_sig (golden_sig),
    .busy       (busy4),
    .done       (done4),
    .pass       (pass4),
    .signature  (sig4),
    .sample_cnt (cnt4)
  );

  bist_misr_analyzer #(.WIDTH(9), .TEST_LEN(2), .SEED(9'h000)) u_dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start & sel),
`ifdef BIST_MISR_ABORT_EN
    .abort      (1'b0),
`endif
    .resp_valid (resp_valid & sel),
    .resp_data  (resp_data),
    .golden_sig (golden_sig),
    .busy       (busy2),
    .done       (done2),
    .pass       (pass2),
    .signature  (sig2),
    .sample_cnt (cnt2)
  );

  assign obs_busy = sel ? busy2 : busy4;
  assign obs_done = sel ? done2 : done4;
  assign obs_pass = sel ? pass2 : pass4;
  assign obs_sig  = sel ? sig2  : sig4;
  assign obs_cnt  = sel ? cnt2  : cnt4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference MISR written bit by bit from x^9+x^5+1
  function automatic logic [8:0] misr_model(input logic [8:0] s, input logic [8:0] d);
    logic [8:0] n;
    logic       fb;
    fb   = s[8];
    n[0] = fb ^ d[0];
    for (int i = 1; i < 9; i++) n[i] = s[i-1] ^ d[i];
    n[5] = n[5] ^ fb;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive stim[] through one full run; gaps inserts idle cycles, poke pulses start during them
  task automatic run(input logic [8:0] gold, input bit gaps, input bit poke);
    int         n;
    int         w;
    logic [8:0] m;
    logic [9:0] e;
    n = stim.size();
    m = 9'h000;
    golden_sig = gold;
    pulse_start();
    check("busy_after_start", 32'(obs_busy), 32'd1);
    check("sig_after_start", 32'(obs_sig), 32'(m));
    check("cnt_after_start", 32'(obs_cnt), 32'd0);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) begin
        resp_valid = 1'b0;
        start      = poke;
        tick();
        start = 1'b0;
        check("busy_in_gap", 32'(obs_busy), 32'd1);
        check("cnt_in_gap", 32'(obs_cnt), 32'(k));
        check("sig_in_gap", 32'(obs_sig), 32'(m));
      end
      resp_valid = 1'b1;
      resp_data  = stim[k];
      m = misr_model(m, stim[k]);
      if (k == n - 1) exp_q.push_back({m, (m == gold)});
      tick();
      resp_valid = 1'b0;
      check("sig_step", 32'(obs_sig), 32'(m));
      check("cnt_step", 32'(obs_cnt), 32'(k + 1));
      if (k < n - 1) check("busy_mid", 32'(obs_busy), 32'd1);
    end
    w = 0;
    while (!obs_done && w < 8) begin
      tick();
      w++;
    end
    check("done_latency", 32'(w), 32'd0);
    e = exp_q.pop_front();
    check("final_sig", 32'(obs_sig), 32'(e[9:1]));
    check("final_pass", 32'(obs_pass), 32'(e[0]));
    check("final_cnt", 32'(obs_cnt), 32'(n));
    check("busy_done", 32'(obs_busy), 32'd0);
    // DONE holds against stray samples
    resp_valid = 1'b1;
    resp_data  = 9'h1FF;
    tick();
    tick();
    resp_valid = 1'b0;
    check("hold_sig", 32'(obs_sig), 32'(e[9:1]));
    check("hold_cnt", 32'(obs_cnt), 32'(n));
    check("hold_done", 32'(obs_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 9'h000;
    golden_sig = 9'h000;
    sel        = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_done", 32'(obs_done), 32'd0);
    check("rst_pass", 32'(obs_pass), 32'd0);
    check("rst_sig", 32'(obs_sig), 32'd0);
    check("rst_cnt", 32'(obs_cnt), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check("no_autostart", 32'(obs_busy), 32'd0);

    // Samples in IDLE are ignored
    resp_valid = 1'b1;
    resp_data  = 9'h155;
    tick();
    tick();
    resp_valid = 1'b0;
    check("idle_sig", 32'(obs_sig), 32'd0);
    check("idle_cnt", 32'(obs_cnt), 32'd0);

    // Four zero samples, golden 0
    stim = '{9'h000, 9'h000, 9'h000, 9'h000};
    run(9'h000, 1'b0, 1'b0);
    check("kat_zero_pass", 32'(obs_pass), 32'd1);

    // 001,0,0,0 -> 008, matching and non-matching golden
    stim = '{9'h001, 9'h000, 9'h000, 9'h000};
    run(9'h008, 1'b0, 1'b0);
    check("kat_008_sig", 32'(obs_sig), 32'h008);
    check("kat_008_pass", 32'(obs_pass), 32'd1);
    run(9'h009, 1'b0, 1'b0);
    check("kat_009_pass", 32'(obs_pass), 32'd0);

    // TEST_LEN=2 instance: 100 then 021
    sel  = 1'b1;
    stim = '{9'h100, 9'h000};
    run(9'h021, 1'b0, 1'b0);
    check("kat_021_sig", 32'(obs_sig), 32'h021);
    check("kat_021_cnt", 32'(obs_cnt), 32'd2);
    sel = 1'b0;

    // Gapped run with start pokes equals the gapless result
    stim = '{9'h0A5, 9'h13C, 9'h1FF, 9'h042};
    run(9'h000, 1'b0, 1'b0);
    m = obs_sig;
    run(9'h000, 1'b1, 1'b1);
    check("gap_vs_gapless", 32'(obs_sig), 32'(m));

    // Reset mid-run after two samples
    pulse_start();
    resp_valid = 1'b1;
    resp_data  = 9'h0A5;
    tick();
    resp_data  = 9'h13C;
    tick();
    resp_valid = 1'b0;
    check("pre_reset_sig", 32'(obs_sig), 32'(misr_model(misr_model(9'h000, 9'h0A5), 9'h13C)));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(obs_busy), 32'd0);
    check("mid_rst_done", 32'(obs_done), 32'd0);
    check("mid_rst_sig", 32'(obs_sig), 32'd0);
    check("mid_rst_cnt", 32'(obs_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 32'(obs_busy), 32'd0);
    stim = '{9'h001, 9'h000, 9'h000, 9'h000};
    run(9'h008, 1'b0, 1'b0);

`ifdef BIST_MISR_ABORT_EN
    // Abort coincident with the fourth sample
    pulse_start();
    m = 9'h000;
    for (int k = 1; k <= 3; k++) begin
      resp_valid = 1'b1;
      resp_data  = 9'(k);
      m = misr_model(m, 9'(k));
      tick();
    end
    resp_data = 9'h004;
    abort     = 1'b1;
    tick();
    abort      = 1'b0;
    resp_valid = 1'b0;
    check("abort_busy", 32'(obs_busy), 32'd0);
    check("abort_done", 32'(obs_done), 32'd0);
    check("abort_pass", 32'(obs_pass), 32'd0);
    check("abort_cnt", 32'(obs_cnt), 32'd3);
    check("abort_sig", 32'(obs_sig), 32'(m));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
